apb_spi_regif_fifo: RTL

APB_SPI_REGIF_FIFO -- requirements
Module: apb_spi_regif_fifo

---
 rtl/apb_spi_regif_fifo.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/apb_spi_regif_fifo.sv
// APB register interface for an SPI core: control registers, status, and TX/RX FIFOs
// sitting between the APB bus and the shifter.
module apb_spi_regif_fifo #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [15:0]       CR1,
  output logic [7:0]        CR2,
  output logic              IRQ,
  input  logic              TX_RD_EN,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_EMPTY,
  input  logic              RX_WR_EN,
  input  logic [DATA_W-1:0] RX_DATA,
  output logic              RX_FULL,
  input  logic              CORE_BSY
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = 3;

  localparam logic [ADDR_W-1:0] A_CR1   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_CR2   = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_SR    = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_DR    = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_TXLVL = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] A_RXLVL = ADDR_W'(32'h14);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic [15:0]        cr1_q, cr1_d;
  logic [7:0]         cr2_q, cr2_d;
  logic               ovr_q, ovr_d;

  logic [PTR_W-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PTR_W-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [DATA_W-1:0]  tx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  rx_mem_q [FIFO_DEPTH];

  logic               in_access_c, pready_c;
  logic [CNT_W-1:0]   cnt_c;
  logic               sel_cr1_c, sel_cr2_c, sel_sr_c, sel_dr_c, sel_txlvl_c, sel_rxlvl_c;
  logic               err_c, wr_ok_c, rd_ok_c;
  logic [31:0]        rdata_c;
  logic [7:0]         sr_c;
  logic [PTR_W-1:0]   tx_lvl_c, rx_lvl_c;
  logic               tx_empty_c, tx_full_c, rx_empty_c, rx_full_c;
  logic               tx_push_c, tx_pop_c, rx_push_c, rx_pop_c, rx_drop_c;
  logic [DATA_W-1:0]  tx_head_c, rx_head_c;

  // FSM state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state: SETUP is entered once a setup phase has been seen; the first ACCESS cycle
  // is therefore qualified by state SETUP, later wait cycles by state ACCESS.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        if (PSEL && !PENABLE) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        wait_cnt_d = '0;
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE) begin
          if (pready_c) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_ACCESS;
            wait_cnt_d = CNT_W'(1);
          end
        end
      end
      ST_ACCESS: begin
        if (!(PSEL && PENABLE) || pready_c) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    in_access_c = PSEL && PENABLE && (state_q != ST_IDLE);
    cnt_c       = (state_q == ST_ACCESS) ? wait_cnt_q : '0;
    pready_c    = in_access_c && (cnt_c == CNT_W'(WAIT_STATES));
  end

  // FIFO status from registered pointers
  always_comb begin
    tx_lvl_c   = tx_wptr_q - tx_rptr_q;
    rx_lvl_c   = rx_wptr_q - rx_rptr_q;
    tx_empty_c = (tx_wptr_q == tx_rptr_q);
    rx_empty_c = (rx_wptr_q == rx_rptr_q);
    tx_full_c  = (tx_lvl_c == PTR_W'(FIFO_DEPTH));
    rx_full_c  = (rx_lvl_c == PTR_W'(FIFO_DEPTH));
    tx_head_c  = tx_empty_c ? '0 : tx_mem_q[tx_rptr_q[IDX_W-1:0]];
    rx_head_c  = rx_empty_c ? '0 : rx_mem_q[rx_rptr_q[IDX_W-1:0]];
    sr_c       = {CORE_BSY || !tx_empty_c, ovr_q, 3'b000, tx_full_c, tx_empty_c, !rx_empty_c};
  end

  // Address decode, read mux and error detection
  always_comb begin
    sel_cr1_c   = (PADDR == A_CR1);
    sel_cr2_c   = (PADDR == A_CR2);
    sel_sr_c    = (PADDR == A_SR);
    sel_dr_c    = (PADDR == A_DR);
    sel_txlvl_c = (PADDR == A_TXLVL);
    sel_rxlvl_c = (PADDR == A_RXLVL);
    rdata_c     = '0;
    err_c       = 1'b0;
    if (sel_cr1_c) begin
      rdata_c = 32'(cr1_q);
    end else if (sel_cr2_c) begin
      rdata_c = 32'(cr2_q);
    end else if (sel_sr_c) begin
      rdata_c = 32'(sr_c);
      err_c   = PWRITE && ((PWDATA & ~32'h0000_0040) != 32'h0);
    end else if (sel_dr_c) begin
      rdata_c = 32'(rx_head_c);
      err_c   = PWRITE ? tx_full_c : rx_empty_c;
    end else if (sel_txlvl_c) begin
      rdata_c = 32'(tx_lvl_c);
      err_c   = PWRITE;
    end else if (sel_rxlvl_c) begin
      rdata_c = 32'(rx_lvl_c);
      err_c   = PWRITE;
    end else begin
      err_c   = 1'b1;
    end
    wr_ok_c = pready_c && PWRITE && !err_c;
    rd_ok_c = pready_c && !PWRITE && !err_c;
  end

  // FIFO handshakes; an RX pop in the same cycle makes room for a push at full
  always_comb begin
    tx_push_c = wr_ok_c && sel_dr_c;
    tx_pop_c  = TX_RD_EN && !tx_empty_c;
    rx_pop_c  = rd_ok_c && sel_dr_c;
    rx_push_c = RX_WR_EN && (!rx_full_c || rx_pop_c);
    rx_drop_c = RX_WR_EN && rx_full_c && !rx_pop_c;
  end

  // Register next values
  always_comb begin
    cr1_d     = cr1_q;
    cr2_d     = cr2_q;
    ovr_d     = ovr_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    if (wr_ok_c && sel_cr1_c) cr1_d = PWDATA[15:0];
    if (wr_ok_c && sel_cr2_c) cr2_d = PWDATA[7:0];
    if (tx_push_c) tx_wptr_d = tx_wptr_q + PTR_W'(1);
    if (tx_pop_c)  tx_rptr_d = tx_rptr_q + PTR_W'(1);
    if (rx_push_c) rx_wptr_d = rx_wptr_q + PTR_W'(1);
    if (rx_pop_c)  rx_rptr_d = rx_rptr_q + PTR_W'(1);
    if (wr_ok_c && sel_sr_c && PWDATA[6]) ovr_d = 1'b0;
    if (rx_drop_c) ovr_d = 1'b1;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cr1_q     <= '0;
      cr2_q     <= '0;
      ovr_q     <= 1'b0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      cr1_q     <= cr1_d;
      cr2_q     <= cr2_d;
      ovr_q     <= ovr_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
    end
  end

  // FIFO storage needs no reset: contents are only visible through non-empty pointers
  always_ff @(posedge PCLK) begin
    if (tx_push_c) tx_mem_q[tx_wptr_q[IDX_W-1:0]] <= PWDATA[DATA_W-1:0];
    if (rx_push_c) rx_mem_q[rx_wptr_q[IDX_W-1:0]] <= RX_DATA;
  end

  always_comb begin
    PREADY   = pready_c;
    PSLVERR  = pready_c && err_c;
    PRDATA   = (pready_c && !PWRITE && !err_c) ? rdata_c : '0;
    CR1      = cr1_q;
    CR2      = cr2_q;
    IRQ      = (cr2_q[7] && tx_empty_c) || (cr2_q[6] && !rx_empty_c) || (cr2_q[5] && ovr_q);
    TX_DATA  = tx_head_c;
    TX_EMPTY = tx_empty_c;
    RX_FULL  = rx_full_c;
  end

endmodule
